// File: rtl/alu_mc_if.sv
// Issue/response bundle between operand fetch and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PSW_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             bw;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [PSW_W-1:0] PSW_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wb_en;
    logic             op_err;
    logic [PSW_W-1:0] PSW_o;

    modport master (
        output in_valid, op, bw, src, dst, PSW_i, out_ready,
        input  in_ready, out_valid, result, wb_en, op_err, PSW_o
    );

    modport slave (
        input  in_valid, op, bw, src, dst, PSW_i, out_ready,
        output in_ready, out_valid, result, wb_en, op_err, PSW_o
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle byte/word ALU: one op per handshake, BCD add ripples one nibble per cycle.
// PSW layout V S N Z C at bits 4..0; only C, Z, N, V are ever rewritten.
module alu_mc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PSW_W = 16
) (
    input logic     Clock,
    input logic     Reset,
    alu_mc_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = $clog2(NIB) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCD, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_DADD, OP_CMP, OP_XOR, OP_AND,
        OP_BIT, OP_BIC, OP_BIS, OP_SRA, OP_RRC, OP_IL13, OP_IL14, OP_IL15
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q;
    logic             bw_q;
    logic [WIDTH-1:0] src_q, dst_q, acc_q;
    logic [PSW_W-1:0] psw_q;
    logic             cy_q;
    logic [CW-1:0]    nib_q;

    logic [WIDTH-1:0] result_q;
    logic [PSW_W-1:0] psw_o_q;
    logic             out_valid_q, wb_en_q, op_err_q;
    logic             in_ready_c;

    // ---------------- FSM ----------------
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    logic bcd_last;

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_d = (op_t'(bus.op) == OP_DADD) ? S_BCD : S_EXEC;
            end
            S_EXEC: state_d = S_DONE;
            S_BCD:  if (bcd_last) state_d = S_DONE;
            S_DONE: if (out_valid_q && bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    logic             sub_op, cin, d_msb, s_msb, r_msb, r_zero, shift_in, arith_c;
    logic [WIDTH-1:0] s_eff, arith_r, logic_r, shift_r, ex_r, ex_out;
    logic [WIDTH:0]   sum_w;
    logic [8:0]       sum_b;
    logic [PSW_W-1:0] ex_psw;
    logic             ex_wb, ex_err;

    always_comb begin
        sub_op = op_q inside {OP_SUB, OP_SUBC, OP_CMP};
        s_eff  = sub_op ? ~src_q : src_q;
        cin    = psw_q[0];
        if (op_q == OP_ADD) cin = 1'b0;
        if (op_q == OP_SUB || op_q == OP_CMP) cin = 1'b1;
        sum_w   = {1'b0, dst_q} + {1'b0, s_eff} + (WIDTH+1)'(cin);
        sum_b   = {1'b0, dst_q[7:0]} + {1'b0, s_eff[7:0]} + 9'(cin);
        d_msb   = bw_q ? dst_q[7] : dst_q[WIDTH-1];
        s_msb   = bw_q ? s_eff[7] : s_eff[WIDTH-1];
        arith_r = bw_q ? {dst_q[WIDTH-1:8], sum_b[7:0]} : sum_w[WIDTH-1:0];
        arith_c = bw_q ? sum_b[8] : sum_w[WIDTH];

        shift_in = (op_q == OP_SRA) ? d_msb : psw_q[0];
        shift_r  = bw_q ? {dst_q[WIDTH-1:8], shift_in, dst_q[7:1]}
                        : {shift_in, dst_q[WIDTH-1:1]};

        logic_r = dst_q | src_q;
        case (op_q)
            OP_XOR:         logic_r = dst_q ^ src_q;
            OP_AND, OP_BIT: logic_r = dst_q & src_q;
            OP_BIC:         logic_r = dst_q & ~src_q;
            default:        logic_r = dst_q | src_q;
        endcase
        if (bw_q) logic_r[WIDTH-1:8] = dst_q[WIDTH-1:8];

        ex_r = dst_q;
        case (op_q)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP:  ex_r = arith_r;
            OP_XOR, OP_AND, OP_BIT, OP_BIC, OP_BIS:    ex_r = logic_r;
            OP_SRA, OP_RRC:                            ex_r = shift_r;
            default:                                   ex_r = dst_q;
        endcase
        r_msb  = bw_q ? ex_r[7] : ex_r[WIDTH-1];
        r_zero = bw_q ? (ex_r[7:0] == '0) : (ex_r == '0);

        ex_psw = psw_q;
        ex_wb  = 1'b1;
        ex_err = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                ex_psw[0] = arith_c;
                ex_psw[1] = r_zero;
                ex_psw[2] = r_msb;
                ex_psw[4] = (d_msb == s_msb) && (r_msb != s_msb);
            end
            OP_XOR, OP_AND, OP_BIT: begin
                ex_psw[0] = ~r_zero;
                ex_psw[1] = r_zero;
                ex_psw[2] = r_msb;
                ex_psw[4] = 1'b0;
            end
            OP_BIC, OP_BIS: ;
            OP_SRA, OP_RRC: begin
                ex_psw[0] = dst_q[0];
                ex_psw[1] = r_zero;
                ex_psw[2] = r_msb;
                ex_psw[4] = 1'b0;
            end
            default: begin
                ex_err = 1'b1;
                ex_wb  = 1'b0;
            end
        endcase
        if (op_q == OP_CMP || op_q == OP_BIT) ex_wb = 1'b0;
        ex_out = (op_q == OP_CMP) ? dst_q : ex_r;
    end

    // ---------------- BCD nibble step ----------------
    logic [CW+1:0]    nib_base;
    logic [4:0]       bcd_t;
    logic [3:0]       bcd_dig;
    logic             bcd_cy;
    logic [WIDTH-1:0] bcd_r;
    logic [PSW_W-1:0] bcd_psw;

    always_comb begin
        nib_base = {nib_q, 2'b00};
        bcd_t    = {1'b0, dst_q[nib_base +: 4]} + {1'b0, src_q[nib_base +: 4]} + 5'(cy_q);
        bcd_cy   = bcd_t > 5'd9;
        bcd_dig  = bcd_cy ? 4'(bcd_t - 5'd10) : bcd_t[3:0];
        bcd_r    = acc_q;
        bcd_r[nib_base +: 4] = bcd_dig;
        bcd_last = nib_q == (bw_q ? CW'(1) : CW'(NIB - 1));
        bcd_psw    = psw_q;
        bcd_psw[0] = bcd_cy;
        bcd_psw[1] = bw_q ? (bcd_r[7:0] == '0) : (bcd_r == '0);
        bcd_psw[2] = bw_q ? bcd_r[7] : bcd_r[WIDTH-1];
    end

    // ---------------- registers ----------------
    // Results land on the last compute edge; out_valid follows one edge later.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q        <= OP_ADD;
            bw_q        <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            acc_q       <= '0;
            psw_q       <= '0;
            cy_q        <= 1'b0;
            nib_q       <= '0;
            result_q    <= '0;
            psw_o_q     <= '0;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    op_q  <= op_t'(bus.op);
                    bw_q  <= bus.bw;
                    src_q <= bus.src;
                    dst_q <= bus.dst;
                    acc_q <= bus.dst;
                    psw_q <= bus.PSW_i;
                    cy_q  <= bus.PSW_i[0];
                    nib_q <= '0;
                end
                S_EXEC: begin
                    result_q <= ex_out;
                    psw_o_q  <= ex_psw;
                    wb_en_q  <= ex_wb;
                    op_err_q <= ex_err;
                end
                S_BCD: begin
                    acc_q <= bcd_r;
                    cy_q  <= bcd_cy;
                    nib_q <= nib_q + CW'(1);
                    if (bcd_last) begin
                        result_q <= bcd_r;
                        psw_o_q  <= bcd_psw;
                        wb_en_q  <= 1'b1;
                        op_err_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q)         out_valid_q <= 1'b1;
                    else if (bus.out_ready)   out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.PSW_o     = psw_o_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.op_err    = op_err_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops against an integer model.
module tb_alu_mc;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned PSW_W = 16;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    alu_mc_if #(.WIDTH(WIDTH), .PSW_W(PSW_W)) bus ();
    alu_mc #(.WIDTH(WIDTH), .PSW_W(PSW_W)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] p;
        logic        wb;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference computed from the arithmetic rules on plain integers.
    function automatic exp_t model(input int op, input bit bw, input int src, input int dst, input int psw);
        exp_t e;
        int n, mask, d, s, s2, c, v, sum, r, fr, cy, t, dig;
        bit upd;
        n = bw ? 8 : 16;
        mask = (1 << n) - 1;
        d = dst & mask;
        s = src & mask;
        c = psw & 1;
        v = (psw >> 4) & 1;
        upd = 1'b1;
        e.wb = 1'b1;
        e.err = 1'b0;
        e.lat = 8'd2;
        fr = 0;
        r = d;
        case (op)
            0, 1, 2, 3, 5: begin
                s2  = (op == 2 || op == 3 || op == 5) ? (~s & mask) : s;
                sum = d + s2 + ((op == 0) ? 0 : (op == 2 || op == 5) ? 1 : c);
                fr  = sum & mask;
                c   = (sum >> n) & 1;
                v   = int'((((d ^ s2) >> (n - 1)) & 1) == 0 && (((fr ^ s2) >> (n - 1)) & 1) == 1);
                r   = (op == 5) ? d : fr;
                if (op == 5) e.wb = 1'b0;
            end
            4: begin
                cy = c;
                for (int i = 0; i < n / 4; i++) begin
                    t = ((d >> (4 * i)) & 15) + ((s >> (4 * i)) & 15) + cy;
                    if (t > 9) begin dig = (t - 10) & 15; cy = 1; end
                    else       begin dig = t;             cy = 0; end
                    fr = fr | (dig << (4 * i));
                end
                r = fr;
                c = cy;
                e.lat = bw ? 8'd3 : 8'd5;
            end
            6, 7, 8: begin
                fr = (op == 6) ? (d ^ s) : (d & s);
                r  = fr;
                c  = int'(fr != 0);
                v  = 0;
                if (op == 8) e.wb = 1'b0;
            end
            9:  begin r = d & ~s & mask; upd = 1'b0; end
            10: begin r = d | s;         upd = 1'b0; end
            11, 12: begin
                fr = (op == 11) ? ((d >> 1) | (d & (1 << (n - 1)))) : ((d >> 1) | (c << (n - 1)));
                r  = fr;
                c  = d & 1;
                v  = 0;
            end
            default: begin upd = 1'b0; e.err = 1'b1; e.wb = 1'b0; end
        endcase
        e.r = 16'((dst & ~mask) | r);
        if (upd)
            e.p = 16'((psw & ~32'h17) | (v << 4) | (((fr >> (n - 1)) & 1) << 2) | (int'(fr == 0) << 1) | c);
        else
            e.p = 16'(psw);
        return e;
    endfunction

    task automatic run_op(input string tag, input int op, input bit bw,
                          input int src, input int dst, input int psw, input int hold);
        exp_t e;
        int lat;
        e = model(op, bw, src, dst, psw);
        @(negedge Clock);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op = 4'(op);
        bus.bw = bw;
        bus.src = 16'(src);
        bus.dst = 16'(dst);
        bus.PSW_i = 16'(psw);
        bus.in_valid = 1'b1;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.src = 16'($urandom);
        bus.dst = 16'($urandom);
        bus.PSW_i = 16'($urandom);
        check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (lat < 40 && bus.out_valid !== 1'b1) begin
            @(posedge Clock); #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(e.lat));
        check({tag, ".result"}, 32'(bus.result), 32'(e.r));
        check({tag, ".psw"}, 32'(bus.PSW_o), 32'(e.p));
        check({tag, ".wb_en"}, 32'(bus.wb_en), 32'(e.wb));
        check({tag, ".op_err"}, 32'(bus.op_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge Clock); #1;
            check({tag, ".hold_result"}, 32'(bus.result), 32'(e.r));
            check({tag, ".hold_psw"}, 32'(bus.PSW_o), 32'(e.p));
            check({tag, ".hold_valid"}, 32'({bus.out_valid, bus.in_ready}), 32'b10);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        bus.out_ready = 1'b0;
        check({tag, ".release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        Reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.bw = 1'b0;
        bus.src = '0;
        bus.dst = '0;
        bus.PSW_i = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.outs", 32'({bus.out_valid, bus.wb_en, bus.op_err}), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.psw", 32'(bus.PSW_o), 32'd0);
        Reset = 1'b0;

        run_op("add_ovf",   0, 1'b0, 32'h0001, 32'h7FFF, 32'h0000, 0);
        run_op("sub_b",     2, 1'b1, 32'h0034, 32'h1234, 32'h0000, 0);
        run_op("dadd_w",    4, 1'b0, 32'h0001, 32'h0999, 32'h0000, 0);
        run_op("dadd_wrap", 4, 1'b0, 32'h0001, 32'h9999, 32'h0000, 0);
        run_op("dadd_b",    4, 1'b1, 32'h0058, 32'hAB47, 32'h0001, 0);
        run_op("rrc_b",    12, 1'b1, 32'h0000, 32'hAB01, 32'h0001, 0);
        run_op("sra_b",    11, 1'b1, 32'h0000, 32'h12F3, 32'h0010, 0);
        run_op("cmp_eq",    5, 1'b0, 32'h0005, 32'h0005, 32'hFF00, 0);
        run_op("backpress", 1, 1'b0, 32'h8000, 32'h8000, 32'h0001, 10);
        run_op("illegal14",14, 1'b0, 32'h1111, 32'h2222, 32'hABCD, 0);
        run_op("bic_w",     9, 1'b0, 32'h0F0F, 32'hFFFF, 32'h0017, 0);

        // Reset lands while the second BCD nibble is being processed.
        @(negedge Clock);
        bus.op = 4'd4;
        bus.bw = 1'b0;
        bus.src = 16'h0001;
        bus.dst = 16'h0999;
        bus.PSW_i = 16'h0000;
        bus.in_valid = 1'b1;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("mid_reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_reset.outs", 32'({bus.out_valid, bus.wb_en, bus.op_err}), 32'd0);
        check("mid_reset.result", 32'(bus.result), 32'd0);
        check("mid_reset.psw", 32'(bus.PSW_o), 32'd0);
        run_op("after_reset", 3, 1'b0, 32'h0001, 32'h0000, 32'h0000, 0);

        for (int k = 0; k < 80; k++) begin
            run_op("rand", int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF),
                   int'($urandom & 32'hFFFF), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
